// File: rtl/cycle_counter_dump_ctrl_if.sv
// Valid/ready stream carrying tagged counter words from the dump sequencer to the host path.
interface cycle_counter_dump_ctrl_if;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [8:0]  out_tag;
   logic        out_last;

   modport master (
      output out_valid,
      output out_data,
      output out_tag,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_tag,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/cycle_counter_dump_ctrl.sv
// Walks the per-layer counter bank (layer outer, type inner), waits out its read latency,
// and streams every captured word with its {layer,type} tag over a valid/ready port.
module cycle_counter_dump_ctrl #(
   parameter int unsigned MAX_LAYERS = 32,
   parameter int unsigned NUM_TYPES  = 7,
   parameter int unsigned READ_LAT   = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       abort,
   input  logic [6:0]                 num_layers,
   input  logic [31:0]                cycle_data,
   output logic [5:0]                 layer_selc,
   output logic [2:0]                 layer_type,
   cycle_counter_dump_ctrl_if.master  out_if,
   output logic                       busy,
   output logic                       done
);

   localparam int unsigned WW     = (READ_LAT < 1) ? 1 : $clog2(READ_LAT + 1);
   localparam logic [6:0]  MAXL   = 7'(MAX_LAYERS);
   localparam logic [2:0]  LAST_T = 3'(NUM_TYPES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SET,
      S_WAIT,
      S_CAPT,
      S_SEND,
      S_FIN
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [6:0]      r_n;
   logic [5:0]      r_l;
   logic [2:0]      r_t;
   logic [WW-1:0]   r_wait;
   logic [5:0]      r_layer_selc;
   logic [2:0]      r_layer_type;
   logic            r_valid;
   logic [31:0]     r_data;
   logic [8:0]      r_tag;
   logic            r_last;
   logic            r_busy;
   logic            r_done;
   logic [6:0]      w_n_clamp;
   logic            w_is_last;

   assign w_n_clamp = (num_layers > MAXL) ? MAXL : num_layers;
   assign w_is_last = ({1'b0, r_l} == (r_n - 7'd1)) && (r_t == LAST_T);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next = (w_n_clamp == 7'd0) ? S_FIN : S_SET;
            end
         end
         S_SET: begin
            w_next = abort ? S_FIN : S_WAIT;
         end
         S_WAIT: begin
            if (abort) begin
               w_next = S_FIN;
            end else if (r_wait == '0) begin
               w_next = S_CAPT;
            end
         end
         S_CAPT: begin
            w_next = abort ? S_FIN : S_SEND;
         end
         S_SEND: begin
            // abort wins over a same-cycle handshake; the pending word is dropped
            if (abort) begin
               w_next = S_FIN;
            end else if (out_if.out_ready) begin
               w_next = r_last ? S_FIN : S_SET;
            end
         end
         S_FIN: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_n          <= '0;
         r_l          <= '0;
         r_t          <= '0;
         r_wait       <= '0;
         r_layer_selc <= '0;
         r_layer_type <= '0;
         r_valid      <= 1'b0;
         r_data       <= '0;
         r_tag        <= '0;
         r_last       <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_state <= w_next;
         r_busy  <= (w_next != S_IDLE);
         r_done  <= (w_next == S_FIN);
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_n <= w_n_clamp;
                  r_l <= '0;
                  r_t <= '0;
               end
            end
            S_SET: begin
               r_layer_selc <= r_l;
               r_layer_type <= r_t;
               r_wait       <= WW'(READ_LAT);
            end
            S_WAIT: begin
               if (r_wait != '0) begin
                  r_wait <= r_wait - 1'b1;
               end
            end
            S_CAPT: begin
               if (!abort) begin
                  r_data  <= cycle_data;
                  r_tag   <= {r_l, r_t};
                  r_last  <= w_is_last;
                  r_valid <= 1'b1;
               end
            end
            S_SEND: begin
               if (abort) begin
                  r_valid <= 1'b0;
                  r_last  <= 1'b0;
               end else if (out_if.out_ready) begin
                  r_valid <= 1'b0;
                  r_last  <= 1'b0;
                  if (!r_last) begin
                     if (r_t == LAST_T) begin
                        r_t <= '0;
                        r_l <= r_l + 6'd1;
                     end else begin
                        r_t <= r_t + 3'd1;
                     end
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign layer_selc       = r_layer_selc;
   assign layer_type       = r_layer_type;
   assign out_if.out_valid = r_valid;
   assign out_if.out_data  = r_data;
   assign out_if.out_tag   = r_tag;
   assign out_if.out_last  = r_last;
   assign busy             = r_busy;
   assign done             = r_done;

endmodule

// File: tb/tb_cycle_counter_dump_ctrl.sv
// Randomized bench: expected word stream is computed from n*NUM_TYPES enumeration order.
module tb_cycle_counter_dump_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic [6:0]  num_layers;
   logic [31:0] cycle_data;
   logic [5:0]  layer_selc;
   logic [2:0]  layer_type;
   logic        busy;
   logic        done;
   int          n_vec = 0;
   int          n_err = 0;

   cycle_counter_dump_ctrl_if u_if ();

   cycle_counter_dump_ctrl #(
      .MAX_LAYERS (32),
      .NUM_TYPES  (7),
      .READ_LAT   (1)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .num_layers (num_layers),
      .cycle_data (cycle_data),
      .layer_selc (layer_selc),
      .layer_type (layer_type),
      .out_if     (u_if),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // counter bank: one-cycle registered read of value {L,T}*1000
   always @(posedge clk) begin
      if (rst) cycle_data <= '0;
      else     cycle_data <= 32'({layer_selc, layer_type}) * 32'd1000;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic run_dump(input int nl, input int rdy_pct, input int abort_word, input bit poke_start);
      int          ncl;
      int          exp_words;
      int          got = 0;
      int          cyc = 0;
      int          last_hs = -10;
      int          done_cyc = -1;
      int          abort_cyc = -1;
      int          busy_cnt = 0;
      int          vld_cnt = 0;
      bit          seen_done = 0;
      bit          aborted = 0;
      bit          prev_stall = 0;
      logic [31:0] pd;
      logic [8:0]  pt;
      logic [8:0]  etag;
      ncl       = (nl > 32) ? 32 : nl;
      exp_words = ncl * 7;
      start      = 1'b1;
      num_layers = 7'(nl);
      @(posedge clk); #1;
      start = 1'b0;
      while (!seen_done && cyc < 20000) begin
         u_if.out_ready = ($urandom_range(0, 99) < rdy_pct);
         abort = 1'b0;
         if (abort_word >= 0 && !aborted && u_if.out_valid && got == abort_word) begin
            abort = 1'b1;
            u_if.out_ready = 1'b1;
            aborted = 1;
            abort_cyc = cyc;
         end
         if (poke_start && cyc == 3) begin
            start = 1'b1;
            num_layers = 7'd5;
         end
         @(negedge clk);
         if (prev_stall) begin
            chk("stall_data", u_if.out_data, pd);
            chk("stall_tag", u_if.out_tag, pt);
         end
         prev_stall = u_if.out_valid && !u_if.out_ready;
         pd = u_if.out_data;
         pt = u_if.out_tag;
         if (busy) busy_cnt++;
         if (u_if.out_valid) vld_cnt++;
         if (aborted && cyc == abort_cyc + 1) begin
            chk("abort_valid", u_if.out_valid, 0);
            chk("abort_last", u_if.out_last, 0);
         end
         if (u_if.out_valid && u_if.out_ready && !abort) begin
            etag = 9'((got / 7) * 8 + (got % 7));
            chk("tag", u_if.out_tag, etag);
            chk("data", u_if.out_data, 32'(etag) * 32'd1000);
            chk("last", u_if.out_last, (got == exp_words - 1));
            got++;
            last_hs = cyc;
         end
         if (done) begin
            seen_done = 1;
            done_cyc = cyc;
         end
         @(posedge clk); #1;
         start = 1'b0;
         abort = 1'b0;
         cyc++;
      end
      chk("done_seen", seen_done, 1);
      if (abort_word >= 0) begin
         chk("abort_words", got, abort_word);
         chk("abort_done_lat", done_cyc, abort_cyc + 1);
      end else begin
         chk("words", got, exp_words);
         if (exp_words > 0) chk("done_lat", done_cyc, last_hs + 1);
         else begin
            chk("empty_done_lat", done_cyc, 0);
            chk("empty_busy_cycles", busy_cnt, 1);
            chk("empty_valid_cycles", vld_cnt, 0);
         end
      end
      chk("post_busy", busy, 0);
      chk("post_done", done, 0);
      u_if.out_ready = 1'b0;
      num_layers = 7'd0;
   endtask

   initial begin
      int hs;
      int guard;
      rst = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      num_layers = '0;
      u_if.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", u_if.out_valid, 0);
      chk("rst_data", u_if.out_data, 0);
      chk("rst_tag", u_if.out_tag, 0);
      chk("rst_last", u_if.out_last, 0);
      chk("rst_sel", {layer_selc, layer_type}, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_dump(2, 100, -1, 1);    // full-rate dump with an ignored start mid-dump
      run_dump(2, 50, -1, 0);     // backpressure
      run_dump(0, 100, -1, 0);    // empty dump
      run_dump(100, 100, -1, 0);  // clamped to 32 layers
      run_dump(3, 100, 5, 0);     // abort on a handshake cycle
      repeat (2) @(posedge clk);
      #1;
      run_dump(2, 100, -1, 0);    // restart begins at tag 0
      for (int i = 0; i < 4; i++) begin
         run_dump(int'($urandom_range(1, 40)), int'($urandom_range(30, 100)), -1, 0);
      end
      run_dump(int'($urandom_range(2, 6)), int'($urandom_range(40, 100)), int'($urandom_range(0, 13)), 0);

      // reset while waiting on the read of the fourth word
      hs = 0;
      guard = 0;
      start = 1'b1;
      num_layers = 7'd2;
      u_if.out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      while (hs < 3 && guard < 200) begin
         @(negedge clk);
         if (u_if.out_valid && u_if.out_ready) hs++;
         @(posedge clk); #1;
         guard++;
      end
      chk("rst_setup_hs", hs, 3);
      @(posedge clk); #1;
      chk("pre_rst_type", layer_type, 3);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_valid", u_if.out_valid, 0);
      chk("midrst_sel", {layer_selc, layer_type}, 0);
      chk("midrst_out", {u_if.out_data, u_if.out_tag, u_if.out_last}, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("midrst_no_done", done, 0);
      end
      u_if.out_ready = 1'b0;
      @(posedge clk); #1;
      run_dump(1, 100, -1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
